// File: rtl/vseq_pkg.sv
// Shared definitions for the vector sequencer: opcode map, lane geometry,
// FSM states and saturation limits.
package vseq_pkg;
  localparam int VSEQ_LANES  = 16;
  localparam int VSEQ_LANE_W = 16;

  // Full 4-bit opcode map shared with the single-cycle ALU
  localparam logic [3:0] OP_VADD   = 4'h0;
  localparam logic [3:0] OP_VDOT   = 4'h1;
  localparam logic [3:0] OP_SMUL   = 4'h2;
  localparam logic [3:0] OP_VSUB   = 4'h3;
  localparam logic [3:0] OP_VAND   = 4'h4;
  localparam logic [3:0] OP_VOR    = 4'h5;
  localparam logic [3:0] OP_SLL    = 4'h6;
  localparam logic [3:0] OP_SRL    = 4'h7;
  localparam logic [3:0] OP_SRA    = 4'h8;
  localparam logic [3:0] OP_VXOR   = 4'h9;
  localparam logic [3:0] OP_VMIN   = 4'hA;
  localparam logic [3:0] OP_VMAX   = 4'hB;
  localparam logic [3:0] OP_VCMP   = 4'hC;
  localparam logic [3:0] OP_VMOV   = 4'hD;
  localparam logic [3:0] OP_VBCAST = 4'hE;
  localparam logic [3:0] OP_NOP    = 4'hF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;
endpackage

// File: rtl/lane_mac.sv
// One-lane 16x16 multiply plus optional accumulate. Wraps modulo 2^W by default;
// with VSEQ_SAT_EN defined, product and sum are signed-clamped and flagged.
module lane_mac
  import vseq_pkg::*;
#(
  parameter int W = VSEQ_LANE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] acc_in,
  input  logic         mac_mode,
  output logic [W-1:0] sum,
  output logic         clamp
);
`ifdef VSEQ_SAT_EN
  logic signed [2*W-1:0] prod;
  logic signed [W:0]     s_ext;
  logic [W-1:0]          p_sat;
  logic                  p_clamp, s_clamp;

  always_comb begin
    prod    = $signed(a) * $signed(b);
    p_clamp = 1'b0;
    p_sat   = prod[W-1:0];
    if (int'(prod) > SAT_MAX) begin
      p_sat = W'(SAT_MAX); p_clamp = 1'b1;
    end else if (int'(prod) < SAT_MIN) begin
      p_sat = W'(SAT_MIN); p_clamp = 1'b1;
    end
    // One guard bit is enough: both addends are already within W-bit signed range
    s_ext = mac_mode ? ($signed({acc_in[W-1], acc_in}) + $signed({p_sat[W-1], p_sat}))
                     : $signed({p_sat[W-1], p_sat});
    s_clamp = 1'b0;
    sum     = s_ext[W-1:0];
    if (int'(s_ext) > SAT_MAX) begin
      sum = W'(SAT_MAX); s_clamp = 1'b1;
    end else if (int'(s_ext) < SAT_MIN) begin
      sum = W'(SAT_MIN); s_clamp = 1'b1;
    end
    clamp = p_clamp | s_clamp;
  end
`else
  logic [W-1:0] prod;

  // Low W bits of a product are the same for signed and unsigned operands
  always_comb begin
    prod  = a * b;
    sum   = mac_mode ? acc_in + prod : prod;
    clamp = 1'b0;
  end
`endif
endmodule

// File: rtl/vec_seq_ctrl.sv
// Multi-cycle VDOT/SMUL sequencer: one lane MAC per cycle under start/busy/done.
// Saturating arithmetic is selected with VSEQ_SAT_EN.
module vec_seq_ctrl
  import vseq_pkg::*;
#(
  parameter int LANES  = VSEQ_LANES,
  parameter int LANE_W = VSEQ_LANE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              opcode,
  input  logic [LANES*LANE_W-1:0] op_1,
  input  logic [LANES*LANE_W-1:0] op_2,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [LANES*LANE_W-1:0] result
);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  state_t                       state;
  logic [IW-1:0]                idx;
  logic                         is_vdot, sat_seen;
  logic [LANES-1:0][LANE_W-1:0] a_q, b_q, b_nxt;
  logic [LANE_W-1:0]            acc, mac_a, mac_sum;
  logic                         mac_clamp;

  assign mac_a = is_vdot ? a_q[idx] : a_q[0];

  lane_mac #(.W(LANE_W)) u_mac (
    .a       (mac_a),
    .b       (b_q[idx]),
    .acc_in  (acc),
    .mac_mode(is_vdot),
    .sum     (mac_sum),
    .clamp   (mac_clamp)
  );

  // b lane i is dead once consumed, so SMUL products are parked in its slot
  always_comb begin
    b_nxt      = b_q;
    b_nxt[idx] = mac_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      acc      <= '0;
      idx      <= '0;
      sat_seen <= 1'b0;
      is_vdot  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q      <= op_1;
          b_q      <= op_2;
          acc      <= '0;
          idx      <= '0;
          sat_seen <= 1'b0;
          is_vdot  <= (opcode == OP_VDOT);
          busy     <= 1'b1;
          if (opcode == OP_VDOT || opcode == OP_SMUL) begin
            state <= RUN;
          end else begin
            state  <= DONE;
            done   <= 1'b1;
            err    <= 1'b1;
            result <= '0;
          end
        end
        RUN: begin
          acc      <= mac_sum;
          b_q      <= b_nxt;
          sat_seen <= sat_seen | mac_clamp;
          idx      <= idx + 1'b1;
          if (idx == LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            err    <= sat_seen | mac_clamp;
            result <= is_vdot ? {{(LANES-1)*LANE_W{1'b0}}, mac_sum} : b_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
